// File: rtl/main_mem_pkg.sv
// Shared definitions for the main-memory responder and its cache-side users.
package main_mem_pkg;

    localparam int unsigned MAIN_MEM_ADDR_W = 4;
    localparam int unsigned MAIN_MEM_DATA_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Bits needed to hold any value 0..lat; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat < 2) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Latency down-counter: loads LATENCY-2 on request acceptance, decrements
// while waiting, and flags zero so the FSM knows when to perform the access.
module mem_lat_counter
    import main_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero_c
);

    localparam int unsigned CNT_W    = cnt_width(LATENCY);
    localparam int unsigned LOAD_VAL = (LATENCY >= 2) ? (LATENCY - 2) : 0;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(LOAD_VAL);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/main_mem_responder.sv
// Main-memory responder: one outstanding read/write, fixed programmable
// latency, one-cycle completion pulse. Optional access statistics are
// enabled with the MAIN_MEM_STATS_EN macro.
module main_mem_responder
    import main_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W   = MAIN_MEM_ADDR_W,
    parameter int unsigned       DATA_W   = MAIN_MEM_DATA_W,
    parameter int unsigned       LATENCY  = 4,
    parameter logic [DATA_W-1:0] INIT_XOR = DATA_W'(8'hA0)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [DATA_W-1:0] mem_req_datain,
    input  logic              mem_req_rw,
    input  logic              mem_req_valid,
    output logic              mem_req_ready,
    output logic [DATA_W-1:0] mem_resp_dataout,
    output logic              mem_resp_valid
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    if (LATENCY < 1 || LATENCY > 255) begin : g_latency_check
        $error("main_mem_responder: LATENCY must be in 1..255");
    end

    logic [1:0]        state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic              rw_q,      rw_d;
    logic [DATA_W-1:0] dataout_q, dataout_d;
    logic              ready_q,   ready_d;
    logic              rvalid_q,  rvalid_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero_c;
    logic              op_go;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_data;
    logic              op_rw;

    mem_lat_counter #(
        .LATENCY (LATENCY)
    ) u_lat_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (cnt_load),
        .dec    (cnt_dec),
        .zero_c (cnt_zero_c)
    );

    // FSM next state, request latch, and the single storage access per request.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rw_d      = rw_q;
        dataout_d = dataout_q;
        mem_d     = mem_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        op_go     = 1'b0;
        op_addr   = addr_q;
        op_data   = data_q;
        op_rw     = rw_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_req_valid && ready_q) begin
                    addr_d = mem_req_addr;
                    data_d = mem_req_datain;
                    rw_d   = mem_req_rw;
                    if (LATENCY == 1) begin
                        // Single-cycle latency: access happens on acceptance.
                        op_go   = 1'b1;
                        op_addr = mem_req_addr;
                        op_data = mem_req_datain;
                        op_rw   = mem_req_rw;
                        state_d = ST_RESP;
                    end else begin
                        cnt_load = 1'b1;
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_zero_c) begin
                    op_go   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Write commits before the response pulse so a following read sees it.
        if (op_go) begin
            if (op_rw == RW_WRITE) begin
                mem_d[op_addr] = op_data;
                dataout_d      = op_data;
            end else begin
                dataout_d = mem_q[op_addr];
            end
        end

        ready_d  = (state_d == ST_IDLE);
        rvalid_d = (state_d == ST_RESP);
    end

    // Control and datapath registers; reset discards any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            rw_q      <= RW_READ;
            dataout_q <= '0;
            ready_q   <= 1'b1;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rw_q      <= rw_d;
            dataout_q <= dataout_d;
            ready_q   <= ready_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Backing store; every entry resets to its index XOR the init pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_W'(i) ^ INIT_XOR;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign mem_req_ready    = ready_q;
    assign mem_resp_dataout = dataout_q;
    assign mem_resp_valid   = rvalid_q;

`ifdef MAIN_MEM_STATS_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    // Saturating access counters, bumped on the edge that enters RESP.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (op_go) begin
            if (op_rw == RW_WRITE) begin
                if (wr_count_q != 16'hFFFF) begin
                    wr_count_d = wr_count_q + 16'd1;
                end
            end else begin
                if (rd_count_q != 16'hFFFF) begin
                    rd_count_d = rd_count_q + 16'd1;
                end
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: transaction-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_main_mem_responder;

    localparam int L = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_addr;
    logic [7:0] req_din;
    logic       req_rw;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] resp_dout;
    logic       resp_valid;
`ifdef MAIN_MEM_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    main_mem_responder #(
        .ADDR_W   (4),
        .DATA_W   (8),
        .LATENCY  (L),
        .INIT_XOR (8'hA0)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_req_addr     (req_addr),
        .mem_req_datain   (req_din),
        .mem_req_rw       (req_rw),
        .mem_req_valid    (req_valid),
        .mem_req_ready    (req_ready),
        .mem_resp_dataout (resp_dout),
        .mem_resp_valid   (resp_valid)
`ifdef MAIN_MEM_STATS_EN
        ,
        .rd_count         (rd_count),
        .wr_count         (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents plus the single outstanding request.
    logic [7:0] m_mem [16];
    bit         m_pend;
    int         m_acc;
    logic [3:0] m_addr;
    logic [7:0] m_data;
    logic       m_rw;
    int         n_edge;
    int         m_accepts;
    int         m_rd;
    int         m_wr;
    logic       exp_ready;
    logic       exp_valid;
    logic [7:0] exp_data;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'(i) ^ 8'hA0;
        m_pend    = 1'b0;
        m_acc     = 0;
        m_rd      = 0;
        m_wr      = 0;
        exp_ready = 1'b1;
        exp_valid = 1'b0;
        exp_data  = 8'h00;
    endtask

    // Advance the model one clock: response due LATENCY-1 edges after the
    // accepting edge, idle again one edge later.
    always @(posedge clk) begin
        if (rst_n) begin
            n_edge++;
            exp_valid = 1'b0;
            if (m_pend && n_edge == m_acc + L) begin
                m_pend = 1'b0;
            end else if (!m_pend && req_valid) begin
                m_pend = 1'b1;
                m_acc  = n_edge;
                m_addr = req_addr;
                m_data = req_din;
                m_rw   = req_rw;
                m_accepts++;
            end
            if (m_pend && n_edge == m_acc + L - 1) begin
                if (m_rw) begin
                    m_mem[m_addr] = m_data;
                    exp_data      = m_data;
                    m_wr++;
                end else begin
                    exp_data = m_mem[m_addr];
                    m_rd++;
                end
                exp_valid = 1'b1;
            end
            exp_ready = !m_pend;
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ready", 32'(req_ready), 32'(exp_ready));
            check("resp_valid", 32'(resp_valid), 32'(exp_valid));
            check("resp_dataout", 32'(resp_dout), 32'(exp_data));
`ifdef MAIN_MEM_STATS_EN
            check("rd_count", 32'(rd_count), 32'(m_rd));
            check("wr_count", 32'(wr_count), 32'(m_wr));
`endif
        end
    end

    // One request with valid held for a single cycle; returns data and the
    // number of cycles from acceptance to the response pulse.
    task automatic do_req(input logic [3:0] a, input logic [7:0] d, input logic w,
                          output logic [7:0] got, output int lat);
        int guard;
        guard = 0;
        got   = 8'h00;
        lat   = -1;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_addr  = a;
        req_din   = d;
        req_rw    = w;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (resp_valid) got = resp_dout;
        else check("resp_timeout", 32'(resp_valid), 32'd1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_dataout", 32'(resp_dout), 32'd0);
`ifdef MAIN_MEM_STATS_EN
        check("rst_rd_count", 32'(rd_count), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] got;
        int lat;
        int acc0;
        int pulses;

        n_edge    = 0;
        m_accepts = 0;
        req_addr  = '0;
        req_din   = '0;
        req_rw    = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        apply_reset();

        // Read of a reset-pattern entry and its exact latency.
        do_req(4'hA, 8'h00, 1'b0, got, lat);
        check("read_A_data", 32'(got), 32'hAA);
        check("read_A_latency", 32'(lat), 32'd4);
        @(negedge clk);
        check("ready_after_resp", 32'(req_ready), 32'd1);

        // Write followed by read of the same address returns the new data.
        do_req(4'hB, 8'hC0, 1'b1, got, lat);
        check("write_B_echo", 32'(got), 32'hC0);
        @(negedge clk);
        do_req(4'hB, 8'h00, 1'b0, got, lat);
        check("read_B_new", 32'(got), 32'hC0);
        @(negedge clk);

        // Valid held high with changing inputs: one acceptance every 5 cycles.
        acc0   = m_accepts;
        pulses = 0;
        req_valid = 1'b1;
        for (int i = 0; i < 25; i++) begin
            req_addr = 4'($urandom);
            req_din  = 8'($urandom);
            req_rw   = 1'($urandom);
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        check("held_valid_accepts", 32'(m_accepts - acc0), 32'd5);
        check("held_valid_responses", 32'(pulses), 32'd5);

        // Reset two cycles into a write: nothing committed, no response.
        req_addr  = 4'h3;
        req_din   = 8'h55;
        req_rw    = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        apply_reset();
        pulses = 0;
        for (int i = 0; i < L + 2; i++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        check("no_resp_after_reset", 32'(pulses), 32'd0);
        do_req(4'h3, 8'h00, 1'b0, got, lat);
        check("read_3_after_reset", 32'(got), 32'hA3);
        @(negedge clk);

`ifdef MAIN_MEM_STATS_EN
        @(negedge clk);
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            do_req(4'(i), 8'(i * 3), (i >= 3) ? 1'b1 : 1'b0, got, lat);
            @(negedge clk);
        end
        check("stats_rd_3", 32'(rd_count), 32'd3);
        check("stats_wr_2", 32'(wr_count), 32'd2);
`endif

        // Randomized traffic with one asynchronous reset midway.
        for (int i = 0; i < 400; i++) begin
            req_valid = 1'($urandom);
            req_addr  = 4'($urandom);
            req_din   = 8'($urandom);
            req_rw    = 1'($urandom);
            if (i == 200) begin
                req_valid = 1'b0;
                #2;
                apply_reset();
            end else begin
                @(negedge clk);
            end
        end
        req_valid = 1'b0;
        repeat (L + 3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
